// File: rtl/wbuf_pkg.sv
// Shared definitions for the weight-buffer slice: derived geometry helpers
// and the write-sequencer state encoding.
package wbuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wbuf_state_e;

  function automatic int unsigned group_size(input int unsigned mem_w,
                                             input int unsigned data_w,
                                             input int unsigned array_m);
    return (data_w * array_m) / mem_w;
  endfunction

  function automatic int unsigned group_id_w(input int unsigned gs);
    return (gs == 1) ? 0 : $clog2(gs);
  endfunction

  function automatic int unsigned buf_id_w(input int unsigned array_n,
                                           input int unsigned gs);
    return $clog2(array_n) + group_id_w(gs);
  endfunction

  function automatic int unsigned num_banks(input int unsigned array_n,
                                            input int unsigned gs);
    return array_n * gs;
  endfunction

  function automatic int unsigned mem_addr_width(input int unsigned buf_addr_w,
                                                 input int unsigned id_w);
    return buf_addr_w + id_w;
  endfunction

endpackage

// File: rtl/wbuf_addr_gen.sv
// Bank/row beat counters for one load command; produces the write address
// {base+row, bank} and flags the final beat of the command.
module wbuf_addr_gen
  import wbuf_pkg::*;
#(
  parameter int unsigned BUF_ADDR_WIDTH = 9,
  parameter int unsigned BUF_ID_W       = 2,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      advance,
  input  logic [BUF_ADDR_WIDTH-1:0] base_addr,
  input  logic [BUF_ADDR_WIDTH:0]   num_rows,
  output logic [MEM_ADDR_WIDTH-1:0] addr,
  output logic                      last_beat
);

  localparam logic [BUF_ADDR_WIDTH:0] ROW_ONE = (BUF_ADDR_WIDTH + 1)'(1);

  logic [BUF_ADDR_WIDTH:0]   row_cnt;
  logic [BUF_ADDR_WIDTH-1:0] row_addr;
  logic                      row_end;
  logic                      last_row;

  // Row address wraps modulo the per-bank depth by truncation.
  assign row_addr  = base_addr + row_cnt[BUF_ADDR_WIDTH-1:0];
  assign last_row  = (row_cnt == (num_rows - ROW_ONE));
  assign last_beat = last_row && row_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt <= '0;
    end else if (clear) begin
      row_cnt <= '0;
    end else if (advance && row_end) begin
      row_cnt <= row_cnt + ROW_ONE;
    end
  end

  if (BUF_ID_W > 0) begin : g_banked
    localparam logic [BUF_ID_W-1:0] LAST_BANK = BUF_ID_W'(NUM_BANKS - 1);
    localparam logic [BUF_ID_W-1:0] BANK_ONE  = BUF_ID_W'(1);

    logic [BUF_ID_W-1:0] bank_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        bank_cnt <= '0;
      end else if (clear) begin
        bank_cnt <= '0;
      end else if (advance) begin
        bank_cnt <= row_end ? '0 : bank_cnt + BANK_ONE;
      end
    end

    assign row_end = (bank_cnt == LAST_BANK);
    assign addr    = {row_addr, bank_cnt};
  end else begin : g_flat
    // Single bank: every beat completes a row.
    assign row_end = 1'b1;
    assign addr    = row_addr;
  end

endmodule

// File: rtl/wbuf_write_ctrl.sv
// Weight-buffer write sequencer: turns a valid/ready beat stream into
// registered banked writes covering cfg_num_rows rows from cfg_base_addr.
module wbuf_write_ctrl
  import wbuf_pkg::*;
#(
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned ARRAY_N        = 4,
  parameter int unsigned ARRAY_M        = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BUF_ADDR_WIDTH = 9,
  parameter int unsigned GROUP_SIZE     = group_size(MEM_DATA_WIDTH, DATA_WIDTH, ARRAY_M),
  parameter int unsigned GROUP_ID_W     = group_id_w(GROUP_SIZE),
  parameter int unsigned BUF_ID_W       = buf_id_w(ARRAY_N, GROUP_SIZE),
  parameter int unsigned NUM_BANKS      = num_banks(ARRAY_N, GROUP_SIZE),
  parameter int unsigned MEM_ADDR_WIDTH = mem_addr_width(BUF_ADDR_WIDTH, BUF_ID_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic [BUF_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [BUF_ADDR_WIDTH:0]   cfg_num_rows,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [MEM_DATA_WIDTH-1:0] s_data,
  input  logic                      s_last,
  output logic                      mem_write_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  wbuf_state_e               state;
  logic [BUF_ADDR_WIDTH-1:0] base_q;
  logic [BUF_ADDR_WIDTH:0]   rows_q;
  logic                      start;
  logic                      accept;
  logic                      last_beat;
  logic [MEM_ADDR_WIDTH-1:0] gen_addr;

  assign start   = cfg_start && (state == IDLE);
  assign s_ready = (state == RUN);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  wbuf_addr_gen #(
    .BUF_ADDR_WIDTH (BUF_ADDR_WIDTH),
    .BUF_ID_W       (BUF_ID_W),
    .NUM_BANKS      (NUM_BANKS),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .advance   (accept),
    .base_addr (base_q),
    .num_rows  (rows_q),
    .addr      (gen_addr),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      base_q <= '0;
      rows_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= cfg_base_addr;
            rows_q <= cfg_num_rows;
            state  <= (cfg_num_rows != '0) ? RUN : DONE;
          end
        end
        RUN:     if (accept && last_beat) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // err flags any disagreement between s_last and the computed final beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (start) begin
      err <= 1'b0;
    end else if (accept && (s_last != last_beat)) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write_req  <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
    end else begin
      mem_write_req <= accept;
      if (accept) begin
        mem_write_addr <= gen_addr;
        mem_write_data <= s_data;
      end
    end
  end

endmodule
